oled_spi_sink: RTL and testbench
================================

Name: oled_spi_sink

Overview:
- SPI peripheral-side receiver for the 4-wire OLED link (SCL, SDA, DC, CS, RES).
- Sits on the picosoc iomem bus as a slave.
- Captures bytes sent by the OLED master, each tagged with the DC level at its last bit, into a FIFO that the CPU reads.
- Used as a loopback monitor for display-driver firmware and as an OLED stand-in for simulation and on-board self-test.

Parameters:
- FIFO_DEPTH, 16: entries in the receive FIFO; power of two, 4..64.
- SYNC_STAGES, 2: flip-flop stages on each pin input; minimum 2.

Ports:
- clk  input  1  system clock; every register is clocked on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- iomem_valid  input  1  bus request.
- iomem_ready  output  1  bus acknowledge; one-cycle pulse.
- iomem_wstrb  input  4  byte strobes; any bit set means write, all zero means read.
- iomem_addr  input  32  address; only [3:2] decoded.
- iomem_wdata  input  32  write data.
- iomem_rdata  output  32  read data; valid while iomem_ready=1.
- spi_sclk  input  1  SPI clock from the master; idle low.
- spi_mosi  input  1  serial data, MSB first.
- spi_cs_n  input  1  chip select, active low.
- spi_dc  input  1  0 = command, 1 = data.
- spi_res_n  input  1  display reset from the master, active low.
- rx_irq  output  1  high while the FIFO is non-empty and enabled.

Behaviour:
- Reset (resetn=0, asynchronous): iomem_ready=0, iomem_rdata=0, rx_irq=0; FIFO empty; bit counter=0; all sticky flags=0; enable=1.
- Input conditioning:
  - All five pins pass through SYNC_STAGES flops.
  - Edges are detected against the previous synchronized value.
  - Supported spi_sclk is at most clk/4.
- SPI FSM, states IDLE, SHIFT:
  - IDLE→SHIFT on synchronized cs_n falling edge; bit counter cleared.
  - In SHIFT, each sclk rising edge shifts mosi in MSB-first and increments the 3-bit counter.
  - On the 8th rising edge, {dc, byte} is pushed one clk later; dc is sampled at that 8th edge. Counter wraps to 0 and the FSM stays in SHIFT.
  - Pin-to-FIFO latency is at most SYNC_STAGES+2 clk cycles.
  - SHIFT→IDLE on cs_n rising. If the counter is non-zero, the partial byte is discarded and FRAME_ERR is set.
  - sclk edges while cs_n is high are ignored.
- Display reset: while the synchronized res_n is low, the FIFO is flushed, the FSM is forced to IDLE, and RES_SEEN is set. RES_SEEN is set on any low, not only a falling edge.
- FIFO:
  - A push when full drops the byte and sets OVERFLOW; the FIFO contents are unchanged.
  - A push and pop in the same cycle leave the count unchanged, including at count=FIFO_DEPTH. In that case the pop is applied first, so no overflow.
  - When enable=0, pushes are suppressed and not flagged.
- Register map (addr[3:2]):
  - 0 RXDATA, read: bit31=valid, bit8=dc, [7:0]=byte. When valid, the read pops one entry. Reading while empty returns 0 and does not pop. Writes are ignored.
  - 1 STATUS, read: [7:0]=count, bit8=OVERFLOW, bit9=FRAME_ERR, bit10=RES_SEEN, bit11=cs active. Write: wdata bits 8..10 = 1 clear the corresponding sticky flag. A set and a clear in the same cycle: the set wins.
  - 2 CTRL: bit0=enable, read/write. Writing 0 does not flush the FIFO.
  - 3: reads 0, writes ignored.
- Bus handshake:
  - When iomem_valid=1 and iomem_ready=0, the next cycle drives iomem_ready=1 for exactly one cycle, with rdata and side effects (pop, clear) applied in that cycle.
  - iomem_ready returns to 0 the following cycle, even if iomem_valid is still high, so every access is single-issue.
  - Response latency is fixed at 1 cycle.
- rx_irq = enable && count!=0, registered.

Decomposition:
- Package oled_spi_sink_pkg:
  - register index constants REG_RXDATA=0, REG_STATUS=1, REG_CTRL=2;
  - status bit positions;
  - entry width 9 ({dc, byte}).
- Sub-module sync_fifo: parameterized width and depth; push, pop, full, empty, count outputs; same-cycle push and pop supported.
- The pin synchronizer stays inline.

Test Plan:
- cs_n low; bytes 0xA5 (dc=0) then 0x3C (dc=1) at clk/8; cs_n high → count=2. RXDATA reads 0x800000A5, then 0x8000013C, then 0x00000000.
- 17 bytes with no reads → count=16, OVERFLOW=1. The first 16 bytes are read back intact in order; the 17th is absent.
- 5 bits sent then cs_n raised → FRAME_ERR=1, count unchanged. A following full byte 0x81 is received correctly. Writing STATUS with bit9=1 clears FRAME_ERR.
- FIFO holds 3 entries; res_n pulsed low for 4 clk → count=0, RES_SEEN=1, FSM in IDLE. A later byte after a fresh cs_n fall is received.
- resetn asserted mid-byte (after 4 bits) → outputs 0 immediately and FIFO empty. After release, a full byte 0x5A is received correctly.
- FIFO full (16 entries); 17th byte's push coincides with the RXDATA read cycle → pop succeeds, count stays 16, OVERFLOW stays 0. iomem_ready is high exactly 1 cycle per access, even with iomem_valid held high for 3 cycles.

Source files
------------

// File: rtl/oled_spi_sink_pkg.sv
// Shared constants for the OLED SPI loopback sink.
// Register indices, status bit positions and FIFO entry layout.
package oled_spi_sink_pkg;

  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_OVF  = 8;
  localparam int ST_FERR = 9;
  localparam int ST_RES  = 10;
  localparam int ST_CS   = 11;

  localparam int RX_VALID = 31;
  localparam int ENTRY_W  = 9;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and same-cycle push/pop.
// A pop frees a slot for a push in the same cycle, even when full.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/oled_spi_sink.sv
// OLED SPI receiver on the iomem bus: captures {dc, byte}
// from the display link into a FIFO read by the CPU.
module oled_spi_sink
  import oled_spi_sink_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  input  logic        spi_dc,
  input  logic        spi_res_n,
  output logic        rx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q, dc_q, res_q;
  logic sclk_s, mosi_s, cs_s, dc_s, res_s;
  logic prev_sclk, prev_cs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_q <= '0;
      mosi_q <= '0;
      cs_q   <= '1;
      dc_q   <= '0;
      res_q  <= '1;
      prev_sclk <= 1'b0;
      prev_cs   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
      dc_q   <= {dc_q[SYNC_STAGES-2:0], spi_dc};
      res_q  <= {res_q[SYNC_STAGES-2:0], spi_res_n};
      prev_sclk <= sclk_s;
      prev_cs   <= cs_s;
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign dc_s   = dc_q[SYNC_STAGES-1];
  assign res_s  = res_q[SYNC_STAGES-1];

  logic sclk_rise, cs_fall, cs_rise, res_active;

  assign sclk_rise  = sclk_s & ~prev_sclk;
  assign cs_fall    = prev_cs & ~cs_s;
  assign cs_rise    = ~prev_cs & cs_s;
  assign res_active = ~res_s;

  logic         state;
  logic [2:0]   bit_cnt;
  logic [6:0]   shreg;
  logic         push_q;
  entry_t       push_data;
  logic         frame_set;

  assign frame_set = (state == SHIFT) & cs_rise
                   & (bit_cnt != 3'd0) & ~res_active;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
    end else begin
      push_q <= 1'b0;
      if (res_active) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= SHIFT;
              bit_cnt <= '0;
            end
          end
          default: begin
            if (cs_rise) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end else if (sclk_rise) begin
              shreg   <= {shreg[5:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              // dc is taken at the same edge as the last data bit
              if (bit_cnt == 3'd7) begin
                push_q    <= 1'b1;
                push_data <= {dc_s, shreg, mosi_s};
              end
            end
          end
        endcase
      end
    end
  end

  logic         access, wr, rd;
  logic [1:0]   reg_sel;
  logic         enable;
  logic         overflow, frame_err, res_seen;
  logic         fifo_full, fifo_empty, pop, push_en, ovf_set;
  logic [AW:0]  fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [2:0]   clr;
  logic [31:0]  rd_val;
  logic         unused_ok;

  assign access  = iomem_valid & ~iomem_ready;
  assign wr      = access & (|iomem_wstrb);
  assign rd      = access & ~(|iomem_wstrb);
  assign reg_sel = iomem_addr[3:2];
  assign pop     = rd & (reg_sel == REG_RXDATA) & ~fifo_empty;
  assign push_en = push_q & enable;
  assign ovf_set = push_en & fifo_full & ~pop;
  assign clr     = (wr && reg_sel == REG_STATUS)
                 ? iomem_wdata[ST_RES:ST_OVF] : 3'b000;
  assign unused_ok = ^{iomem_addr[31:4], iomem_addr[1:0],
                       iomem_wdata[31:11], iomem_wdata[7:1]};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (res_active),
    .push   (push_en),
    .wdata  (push_data),
    .pop    (pop),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (reg_sel == REG_RXDATA): begin
        if (!fifo_empty) begin
          rd_val[RX_VALID]     = 1'b1;
          rd_val[ENTRY_W-1:0]  = fifo_head;
        end
      end
      (reg_sel == REG_STATUS): begin
        rd_val[AW:0]    = fifo_count;
        rd_val[ST_OVF]  = overflow;
        rd_val[ST_FERR] = frame_err;
        rd_val[ST_RES]  = res_seen;
        rd_val[ST_CS]   = ~cs_s;
      end
      (reg_sel == REG_CTRL): rd_val[0] = enable;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      enable      <= 1'b1;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
      res_seen    <= 1'b0;
      rx_irq      <= 1'b0;
    end else begin
      iomem_ready <= access;
      iomem_rdata <= rd ? rd_val : 32'h0;
      if (wr && reg_sel == REG_CTRL) enable <= iomem_wdata[0];
      // a set in the same cycle as a clear must win
      overflow  <= ovf_set    | (overflow  & ~clr[0]);
      frame_err <= frame_set  | (frame_err & ~clr[1]);
      res_seen  <= res_active | (res_seen  & ~clr[2]);
      rx_irq    <= enable & ~fifo_empty;
    end
  end

endmodule

// File: tb/tb_oled_spi_sink.sv
// Randomized bench for oled_spi_sink with a queue-based
// reference model of the captured byte stream and flags.
module tb_oled_spi_sink;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        spi_sclk, spi_mosi, spi_cs_n, spi_dc, spi_res_n;
  logic        rx_irq;

  always #5 clk = ~clk;

  oled_spi_sink dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_dc      (spi_dc),
    .spi_res_n   (spi_res_n),
    .rx_irq      (rx_irq)
  );

  int tests = 0;
  int fails = 0;

  logic [8:0] mq[$];
  logic m_ovf, m_ferr, m_res, m_en;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_ferr = 0; m_res = 0; m_en = 1;
  endtask

  task automatic model_byte(input logic dc, input logic [7:0] d);
    if (m_en) begin
      if (mq.size() == 16) m_ovf = 1;
      else mq.push_back({dc, d});
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic [3:0] ws,
                     input logic [31:0] wd, output logic [31:0] r);
    int n;
    @(negedge clk);
    iomem_valid = 1;
    iomem_addr  = {28'h0, a, 2'b00};
    iomem_wstrb = ws;
    iomem_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 8);
    if (!iomem_ready) check("bus_timeout", 32'd0, 32'd1);
    r = iomem_rdata;
    iomem_valid = 0;
    iomem_wstrb = 0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, 4'hF, d, r);
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] r, e;
    bus(2'd0, 4'h0, 32'h0, r);
    e = 32'h0;
    if (mq.size() != 0) e = {1'b1, 22'b0, mq.pop_front()};
    check(tag, r, e);
  endtask

  task automatic chk_status(input string tag, input logic cs_act);
    logic [31:0] r;
    bus(2'd1, 4'h0, 32'h0, r);
    check(tag, r, {20'b0, cs_act, m_res, m_ferr, m_ovf, 8'(mq.size())});
  endtask

  task automatic spi_bit(input logic b);
    spi_sclk = 0;
    spi_mosi = b;
    repeat (4) @(negedge clk);
    spi_sclk = 1;
    repeat (4) @(negedge clk);
    spi_sclk = 0;
  endtask

  task automatic spi_byte(input logic dc, input logic [7:0] d);
    spi_dc = dc;
    for (int i = 7; i >= 0; i--) spi_bit(d[i]);
    model_byte(dc, d);
  endtask

  task automatic cs_low();
    spi_cs_n = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high(input bit partial);
    repeat (2) @(negedge clk);
    spi_cs_n = 1;
    if (partial) m_ferr = 1;
    repeat (6) @(negedge clk);
  endtask

  logic [7:0]  b;
  logic        d;
  logic [31:0] r;
  logic [2:0]  pat;

  initial begin
    resetn = 0;
    iomem_valid = 0; iomem_wstrb = 0; iomem_addr = 0; iomem_wdata = 0;
    spi_sclk = 0; spi_mosi = 0; spi_cs_n = 1; spi_dc = 0; spi_res_n = 1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_irq", {31'b0, rx_irq}, 32'd0);
    resetn = 1;
    repeat (2) @(negedge clk);
    chk_status("rst_status", 0);
    bus(2'd2, 4'h0, 32'h0, r);
    check("rst_ctrl", r, 32'd1);

    // two bytes, command then data
    cs_low();
    chk_status("cs_active", 1);
    spi_byte(0, 8'hA5);
    spi_byte(1, 8'h3C);
    cs_high(0);
    chk_status("two_status", 0);
    check("two_irq", {31'b0, rx_irq}, 32'd1);
    rd_rx("two_rx0");
    rd_rx("two_rx1");
    rd_rx("two_rx_empty");
    repeat (2) @(negedge clk);
    check("two_irq_off", {31'b0, rx_irq}, 32'd0);

    // overflow with 17 random bytes
    cs_low();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      d = 1'($urandom_range(0, 1));
      spi_byte(d, b);
    end
    cs_high(0);
    chk_status("ovf_status", 0);
    for (int i = 0; i < 17; i++) rd_rx($sformatf("ovf_rx%0d", i));
    wr_reg(2'd1, 32'h100);
    m_ovf = 0;
    chk_status("ovf_clear", 0);

    // partial frame
    cs_low();
    spi_dc = 1'($urandom_range(0, 1));
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)));
    cs_high(1);
    chk_status("ferr_status", 0);
    cs_low();
    spi_byte(1'($urandom_range(0, 1)), 8'h81);
    cs_high(0);
    rd_rx("ferr_rx81");
    wr_reg(2'd1, 32'h200);
    m_ferr = 0;
    chk_status("ferr_clear", 0);

    // display reset mid-frame flushes and idles the receiver
    cs_low();
    for (int i = 0; i < 3; i++)
      spi_byte(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) spi_bit(1'($urandom_range(0, 1)));
    spi_res_n = 0;
    repeat (4) @(negedge clk);
    spi_res_n = 1;
    mq.delete();
    m_res = 1;
    repeat (4) @(negedge clk);
    cs_high(0);
    chk_status("res_status", 0);
    check("res_irq", {31'b0, rx_irq}, 32'd0);
    cs_low();
    spi_byte(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    cs_high(0);
    rd_rx("res_rx");
    rd_rx("res_rx_empty");
    wr_reg(2'd1, 32'h400);
    m_res = 0;
    chk_status("res_clear", 0);

    // receive disabled
    wr_reg(2'd2, 32'h0);
    m_en = 0;
    bus(2'd2, 4'h0, 32'h0, r);
    check("dis_ctrl", r, 32'd0);
    cs_low();
    spi_byte(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    cs_high(0);
    chk_status("dis_status", 0);
    check("dis_irq", {31'b0, rx_irq}, 32'd0);
    wr_reg(2'd2, 32'h1);
    m_en = 1;

    // bus reset in the middle of a byte
    cs_low();
    spi_byte(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) spi_bit(1'($urandom_range(0, 1)));
    check("mid_irq_pre", {31'b0, rx_irq}, 32'd1);
    resetn = 0;
    #1;
    check("mid_irq", {31'b0, rx_irq}, 32'd0);
    check("mid_ready", {31'b0, iomem_ready}, 32'd0);
    check("mid_rdata", iomem_rdata, 32'd0);
    spi_cs_n = 1;
    spi_sclk = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    model_reset();
    chk_status("mid_status", 0);
    cs_low();
    spi_byte(1'($urandom_range(0, 1)), 8'h5A);
    cs_high(0);
    rd_rx("mid_rx5a");

    // full FIFO: 17th push lands in the same cycle as a pop
    cs_low();
    for (int i = 0; i < 16; i++)
      spi_byte(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    b = 8'($urandom_range(0, 255));
    d = 1'($urandom_range(0, 1));
    spi_dc = d;
    for (int i = 7; i >= 1; i--) spi_bit(b[i]);
    spi_sclk = 0;
    spi_mosi = b[0];
    repeat (4) @(negedge clk);
    spi_sclk = 1;
    repeat (2) @(negedge clk);
    rd_rx("coin_rx");
    model_byte(d, b);
    repeat (2) @(negedge clk);
    spi_sclk = 0;
    cs_high(0);
    chk_status("coin_status", 0);
    for (int i = 0; i < 17; i++) rd_rx($sformatf("coin_drain%0d", i));

    // valid held for three cycles: one-cycle ready pulses
    @(negedge clk);
    iomem_valid = 1;
    iomem_addr  = 32'h4;
    iomem_wstrb = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pat[i] = iomem_ready;
    end
    iomem_valid = 0;
    @(negedge clk);
    check("hold_pattern", {29'b0, pat}, 32'd5);
    check("hold_release", {31'b0, iomem_ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
